// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_controller transmit path among NREQ requesters.
// Holds the UART write lock for the grantee and forwards its bytes until last, cap or drop.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BYTES = 64,
    parameter int CNTW      = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              uart_lock_req,
    input  logic              uart_lock_res,
    input  logic              uart_write_ready,
    output logic [7:0]        uart_data,
    output logic              uart_data_valid,
    output logic              trunc
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK    = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     scan;
    logic              found;
    logic [CNTW-1:0]   count;
    logic [CNTW-1:0]   count_next;
    logic [NREQ-1:0]   grant_next;
    logic              lock_next;
    logic [7:0]        data_next;
    logic              valid_next;
    logic              trunc_next;

    logic              cur_req;
    logic              cur_last;
    logic [7:0]        cur_data;
    logic              accept;
    logic              at_cap;

    // ptr always holds the index of the current (or most recent) grantee
    assign cur_req  = req[ptr];
    assign cur_last = req_last[ptr];
    assign cur_data = req_data[{ptr, 3'b000} +: 8];
    assign at_cap   = (count == CNTW'(MAX_BYTES - 1));
    assign accept   = |(req_valid & req_ready);

    always_comb begin
        req_ready = '0;
        if (state == XFER && uart_write_ready && uart_lock_res && !uart_data_valid) begin
            req_ready = grant;
        end
    end

    // Scan from ptr+1 upward so the last grantee is considered last
    always_comb begin
        pick  = ptr;
        scan  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            ptr             <= PW'(NREQ - 1);
            count           <= '0;
            grant           <= '0;
            uart_lock_req   <= 1'b0;
            uart_data       <= 8'h00;
            uart_data_valid <= 1'b0;
            trunc           <= 1'b0;
        end else begin
            state           <= state_next;
            ptr             <= ptr_next;
            count           <= count_next;
            grant           <= grant_next;
            uart_lock_req   <= lock_next;
            uart_data       <= data_next;
            uart_data_valid <= valid_next;
            trunc           <= trunc_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (found) state_next = LOCK;
            end
            LOCK: begin
                if (!cur_req)           state_next = RELEASE;
                else if (uart_lock_res) state_next = XFER;
            end
            XFER: begin
                if (accept && (cur_last || at_cap)) state_next = RELEASE;
                else if (!accept && !cur_req)       state_next = RELEASE;
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ptr_next   = ptr;
        count_next = count;
        grant_next = grant;
        lock_next  = uart_lock_req;
        data_next  = uart_data;
        valid_next = 1'b0;
        trunc_next = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    lock_next  = 1'b1;
                    ptr_next   = pick;
                    count_next = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    data_next  = cur_data;
                    valid_next = 1'b1;
                    count_next = count + CNTW'(1);
                    trunc_next = at_cap && !cur_last;
                end
            end
            default: ;
        endcase
        // Lock and grant are already low for the whole RELEASE cycle
        if (state != RELEASE && state_next == RELEASE) begin
            grant_next = '0;
            lock_next  = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-backed byte sources, a simple UART lock model
// and logs of forwarded bytes and grants, compared against hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int MAXB = 4;
    localparam int CW   = 3;
    localparam int QD   = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              uart_lock_req;
    logic              uart_lock_res;
    logic              uart_write_ready;
    logic [7:0]        uart_data;
    logic              uart_data_valid;
    logic              trunc;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BYTES(MAXB), .CNTW(CW)) dut (
        .clock(clock), .reset(reset),
        .req(req), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .uart_lock_req(uart_lock_req), .uart_lock_res(uart_lock_res),
        .uart_write_ready(uart_write_ready),
        .uart_data(uart_data), .uart_data_valid(uart_data_valid), .trunc(trunc)
    );

    always #5 clock = ~clock;

    logic [7:0]      qdat  [NREQ][QD];
    logic            qlast [NREQ][QD];
    int              head  [NREQ];
    int              tail  [NREQ];
    logic [NREQ-1:0] req_en;
    logic [NREQ-1:0] flush;
    logic            wr_ready;
    logic            lock_enable;

    logic [NREQ-1:0] pend;
    logic            ne;
    int              lock_cnt;
    logic [7:0]      dlog  [64];
    logic            dlock [64];
    int              dcount;
    logic [NREQ-1:0] glog  [32];
    int              gcount;
    int              handoffs;
    int              trunc_cnt;
    int              rdy3_cnt;
    int              rdy_any_cnt;
    logic [NREQ-1:0] prev_grant;

    int total;
    int bad;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [7:0] b, input logic last);
        qdat[i][tail[i] % QD]  = b;
        qlast[i][tail[i] % QD] = last;
        tail[i]++;
    endtask

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    // Sources, UART model and monitor: observe at negedge, drive, then sample ready 1 unit later
    initial begin
        for (int i = 0; i < NREQ; i++) head[i] = 0;
        req = '0; req_data = '0; req_valid = '0; req_last = '0;
        uart_lock_res = 1'b0; uart_write_ready = 1'b1;
        pend = '0; ne = 1'b0; lock_cnt = 0; dcount = 0; gcount = 0; handoffs = 0;
        trunc_cnt = 0; rdy3_cnt = 0; rdy_any_cnt = 0; prev_grant = '0;
        forever begin
            @(negedge clock);
            if (uart_data_valid) begin
                if (dcount < 64) begin
                    dlog[dcount]  = uart_data;
                    dlock[dcount] = uart_lock_req;
                end
                dcount++;
            end
            if (trunc) trunc_cnt++;
            if (grant != prev_grant && grant != '0) begin
                if (gcount < 32) glog[gcount] = grant;
                gcount++;
                if (prev_grant != '0) handoffs++;
            end
            prev_grant = grant;
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && head[i] != tail[i]) head[i]++;
                if (flush[i]) head[i] = tail[i];
                ne = (head[i] != tail[i]);
                req[i]            = req_en[i] && ne;
                req_valid[i]      = ne;
                req_data[8*i +: 8] = ne ? qdat[i][head[i] % QD] : 8'h00;
                req_last[i]       = ne && qlast[i][head[i] % QD];
            end
            if (uart_lock_req) lock_cnt++;
            else               lock_cnt = 0;
            uart_lock_res    = uart_lock_req && lock_enable && (lock_cnt >= 2);
            uart_write_ready = wr_ready;
            #1;
            pend = req_valid & req_ready;
            if (req_ready[3]) rdy3_cnt++;
            if (|req_ready)   rdy_any_cnt++;
        end
    end

    initial begin
        int d0, g0, h0, t0, r0, k;
        total = 0; bad = 0;
        for (int i = 0; i < NREQ; i++) tail[i] = 0;
        req_en = '0; flush = '0; wr_ready = 1'b1; lock_enable = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_lock", uart_lock_req, 0);
        checkOutput("rst_dv", uart_data_valid, 0);
        checkOutput("rst_trunc", trunc, 0);
        checkOutput("rst_data", uart_data, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Async reset in the middle of a transfer
        applyStimulus(2, 8'h55, 1'b0);
        applyStimulus(2, 8'h56, 1'b1);
        req_en = 4'b0100;
        k = 0;
        while (!uart_data_valid && k < 30) begin tick(); k++; end
        checkOutput("t1_dv_seen", uart_data_valid, 1);
        checkOutput("t1_grant_pre", grant, 4'b0100);
        checkOutput("t1_lock_pre", uart_lock_req, 1);
        reset = 1'b0;
        #1;
        checkOutput("t1_grant_rst", grant, 0);
        checkOutput("t1_lock_rst", uart_lock_req, 0);
        checkOutput("t1_dv_rst", uart_data_valid, 0);
        req_en = '0;
        flush  = 4'b0100;
        tick();
        flush = '0;
        tick();
        reset = 1'b1;
        tick();

        // Round robin from the reset pointer: 0,1,2,3,0
        d0 = dcount; g0 = gcount; h0 = handoffs;
        applyStimulus(0, 8'h10, 1'b1);
        applyStimulus(0, 8'h14, 1'b1);
        applyStimulus(1, 8'h11, 1'b1);
        applyStimulus(2, 8'h12, 1'b1);
        applyStimulus(3, 8'h13, 1'b1);
        req_en = 4'b1111;
        k = 0;
        while (!(dcount - d0 >= 5 && grant == '0) && k < 150) begin tick(); k++; end
        checkOutput("t3_bytes", dcount - d0, 5);
        checkOutput("t3_d0", dlog[d0],   8'h10);
        checkOutput("t3_d1", dlog[d0+1], 8'h11);
        checkOutput("t3_d2", dlog[d0+2], 8'h12);
        checkOutput("t3_d3", dlog[d0+3], 8'h13);
        checkOutput("t3_d4", dlog[d0+4], 8'h14);
        checkOutput("t3_g0", glog[g0],   4'b0001);
        checkOutput("t3_g1", glog[g0+1], 4'b0010);
        checkOutput("t3_g2", glog[g0+2], 4'b0100);
        checkOutput("t3_g3", glog[g0+3], 4'b1000);
        checkOutput("t3_g4", glog[g0+4], 4'b0001);
        checkOutput("t3_no_gap_skip", handoffs - h0, 0);
        repeat (4) tick();
        checkOutput("t3_grants", gcount - g0, 5);
        req_en = '0;

        // Single message on requester 2
        d0 = dcount; g0 = gcount;
        applyStimulus(2, 8'hA1, 1'b0);
        applyStimulus(2, 8'hA2, 1'b0);
        applyStimulus(2, 8'hA3, 1'b1);
        req_en = 4'b0100;
        k = 0;
        while (!(dcount - d0 >= 3 && grant == '0) && k < 60) begin tick(); k++; end
        checkOutput("t2_grant", glog[g0], 4'b0100);
        checkOutput("t2_bytes", dcount - d0, 3);
        checkOutput("t2_a1", dlog[d0],   8'hA1);
        checkOutput("t2_a2", dlog[d0+1], 8'hA2);
        checkOutput("t2_a3", dlog[d0+2], 8'hA3);
        checkOutput("t2_lock_a2", dlock[d0+1], 1);
        checkOutput("t2_lock_a3", dlock[d0+2], 0);
        req_en = '0;

        // Requester 3 offers data without req while requester 0 is granted
        d0 = dcount; g0 = gcount; r0 = rdy3_cnt;
        applyStimulus(3, 8'h33, 1'b0);
        applyStimulus(3, 8'h34, 1'b0);
        applyStimulus(0, 8'h01, 1'b0);
        applyStimulus(0, 8'h02, 1'b1);
        req_en = 4'b0001;
        k = 0;
        while (!(dcount - d0 >= 2 && grant == '0) && k < 60) begin tick(); k++; end
        checkOutput("t6_grant", glog[g0], 4'b0001);
        checkOutput("t6_bytes", dcount - d0, 2);
        checkOutput("t6_d0", dlog[d0],   8'h01);
        checkOutput("t6_d1", dlog[d0+1], 8'h02);
        checkOutput("t6_ready3", rdy3_cnt - r0, 0);
        req_en = '0;
        flush  = 4'b1000;
        tick();
        flush = '0;
        tick();

        // Byte cap: 6 unterminated bytes on requester 1 are split across two grants
        d0 = dcount; g0 = gcount; t0 = trunc_cnt;
        for (int b = 0; b < 6; b++) applyStimulus(1, 8'hB0 + 8'(b), 1'b0);
        applyStimulus(2, 8'hC0, 1'b1);
        req_en = 4'b0110;
        k = 0;
        while (!(dcount - d0 >= 7 && grant == '0) && k < 150) begin tick(); k++; end
        checkOutput("t4_bytes", dcount - d0, 7);
        checkOutput("t4_b0", dlog[d0],   8'hB0);
        checkOutput("t4_b3", dlog[d0+3], 8'hB3);
        checkOutput("t4_c0", dlog[d0+4], 8'hC0);
        checkOutput("t4_b4", dlog[d0+5], 8'hB4);
        checkOutput("t4_b5", dlog[d0+6], 8'hB5);
        checkOutput("t4_g0", glog[g0],   4'b0010);
        checkOutput("t4_g1", glog[g0+1], 4'b0100);
        checkOutput("t4_g2", glog[g0+2], 4'b0010);
        checkOutput("t4_trunc", trunc_cnt - t0, 1);
        req_en = '0;

        // Backpressure mid-message on requester 3
        d0 = dcount;
        applyStimulus(3, 8'hD0, 1'b0);
        applyStimulus(3, 8'hD1, 1'b0);
        applyStimulus(3, 8'hD2, 1'b1);
        req_en = 4'b1000;
        k = 0;
        while (!(dcount - d0 >= 1) && k < 40) begin tick(); k++; end
        wr_ready = 1'b0;
        r0 = rdy_any_cnt;
        repeat (5) tick();
        checkOutput("t5_ready_stall", rdy_any_cnt - r0, 0);
        checkOutput("t5_bytes_stall", dcount - d0, 1);
        wr_ready = 1'b1;
        k = 0;
        while (!(dcount - d0 >= 3 && grant == '0) && k < 40) begin tick(); k++; end
        repeat (4) tick();
        checkOutput("t5_bytes", dcount - d0, 3);
        checkOutput("t5_d0", dlog[d0],   8'hD0);
        checkOutput("t5_d1", dlog[d0+1], 8'hD1);
        checkOutput("t5_d2", dlog[d0+2], 8'hD2);
        req_en = '0;

        // Request dropped while waiting for the lock
        d0 = dcount;
        lock_enable = 1'b0;
        applyStimulus(0, 8'hE0, 1'b1);
        req_en = 4'b0001;
        k = 0;
        while (grant == '0 && k < 20) begin tick(); k++; end
        checkOutput("t5_abort_grant", grant, 4'b0001);
        repeat (3) tick();
        checkOutput("t5_abort_lock", uart_lock_req, 1);
        req_en = '0;
        k = 0;
        while (grant != '0 && k < 10) begin tick(); k++; end
        checkOutput("t5_abort_release", grant, 0);
        checkOutput("t5_abort_unlock", uart_lock_req, 0);
        checkOutput("t5_abort_nodata", dcount - d0, 0);
        flush = 4'b0001;
        tick();
        flush = '0;
        lock_enable = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
